// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: SYNC 0xAA, ID, LEN, LEN payload bytes [, CHK].
// Define CMD_CHECKSUM_EN to require and verify the trailing XOR checksum byte.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CLKS = 86800
) (
   input  logic        i_Clock,
   input  logic        i_Rst_n,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Cmd_Valid,
   input  logic        i_Cmd_Ready,
   output logic [7:0]  o_Cmd_Id,
   output logic [3:0]  o_Cmd_Len,
   output logic [63:0] o_Cmd_Data,
   output logic        o_Frame_Err,
   output logic        o_Overrun
);

   localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ID      = 3'd1;
   localparam logic [2:0] S_LEN     = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
`ifdef CMD_CHECKSUM_EN
   localparam logic [2:0] S_CHK     = 3'd4;
`endif

   logic [2:0]    state_q, state_d;
   logic [7:0]    id_q, id_d;
   logic [3:0]    len_q, len_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [63:0]   data_q, data_d;
   logic [TW-1:0] tmo_q, tmo_d;
`ifdef CMD_CHECKSUM_EN
   logic [7:0]    chk_q, chk_d;
`endif
   logic          done, err;

   logic          valid_q, ferr_q, ovr_q;
   logic [7:0]    out_id_q;
   logic [3:0]    out_len_q;
   logic [63:0]   out_data_q;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      tmo_d   = '0;
      done    = 1'b0;
      err     = 1'b0;
`ifdef CMD_CHECKSUM_EN
      chk_d   = chk_q;
`endif
      if (state_q != S_IDLE && !i_Rx_DV) begin
         if (tmo_q == TMO_LAST) begin
            err     = 1'b1;
            state_d = S_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
      if (i_Rx_DV) begin
         case (state_q)
            S_IDLE: begin
               if (i_Rx_Byte == 8'hAA) begin
                  state_d = S_ID;
                  cnt_d   = '0;
                  data_d  = '0;
`ifdef CMD_CHECKSUM_EN
                  chk_d   = '0;
`endif
               end
            end
            S_ID: begin
               id_d    = i_Rx_Byte;
               state_d = S_LEN;
`ifdef CMD_CHECKSUM_EN
               chk_d   = i_Rx_Byte;
`endif
            end
            S_LEN: begin
               len_d = i_Rx_Byte[3:0];
`ifdef CMD_CHECKSUM_EN
               chk_d = chk_q ^ i_Rx_Byte;
`endif
               if (i_Rx_Byte > 8'd8) begin
                  err     = 1'b1;
                  state_d = S_IDLE;
               end else if (i_Rx_Byte == 8'd0) begin
`ifdef CMD_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  done    = 1'b1;
                  state_d = S_IDLE;
`endif
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               data_d[{cnt_q[2:0], 3'b000} +: 8] = i_Rx_Byte;
               cnt_d = cnt_q + 4'd1;
`ifdef CMD_CHECKSUM_EN
               chk_d = chk_q ^ i_Rx_Byte;
`endif
               if (cnt_q == len_q - 4'd1) begin
`ifdef CMD_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  done    = 1'b1;
                  state_d = S_IDLE;
`endif
               end
            end
`ifdef CMD_CHECKSUM_EN
            S_CHK: begin
               state_d = S_IDLE;
               if (i_Rx_Byte == chk_q) done = 1'b1;
               else                    err  = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         tmo_q   <= '0;
`ifdef CMD_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         tmo_q   <= tmo_d;
`ifdef CMD_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

   // Output holding register runs independently of the parser; a completing
   // frame may replace the held command on the same edge it is handed off.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         valid_q    <= 1'b0;
         out_id_q   <= '0;
         out_len_q  <= '0;
         out_data_q <= '0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         ferr_q <= err;
         ovr_q  <= 1'b0;
         if (done) begin
            if (!valid_q || i_Cmd_Ready) begin
               valid_q    <= 1'b1;
               out_id_q   <= id_d;
               out_len_q  <= len_d;
               out_data_q <= data_d;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && i_Cmd_Ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_Cmd_Valid = valid_q;
   assign o_Cmd_Id    = out_id_q;
   assign o_Cmd_Len   = out_len_q;
   assign o_Cmd_Data  = out_data_q;
   assign o_Frame_Err = ferr_q;
   assign o_Overrun   = ovr_q;

endmodule
